// File: rtl/life_pkg.sv
// Shared widths, FSM encoding and edge-wrap helpers for the cell neighbourhood reader.
package life_pkg;

    localparam int COORD_W = 8;
    localparam int COUNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABOVE  = 3'd1,
        ST_CENTRE = 3'd2,
        ST_BELOW  = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    // Index below v; at the border it wraps or falls back to 0 (caller masks the contribution).
    function automatic logic [COORD_W-1:0] wrap_dec(input logic [COORD_W-1:0] v,
                                                   input int bound, input bit wrap);
        if (v != '0) return v - COORD_W'(1);
        return wrap ? COORD_W'(bound - 1) : '0;
    endfunction

    // Index above v; at the border both wrap and dead-border modes land on 0.
    function automatic logic [COORD_W-1:0] wrap_inc(input logic [COORD_W-1:0] v,
                                                   input int bound);
        if (int'(v) == bound - 1) return '0;
        return v + COORD_W'(1);
    endfunction

endpackage

// File: rtl/neighbour_row_tap.sv
// Combinational 3-column window on one arena row: partial live count plus the centre bit.
module neighbour_row_tap
    import life_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter bit WRAP  = 1'b1
) (
    input  logic [WIDTH-1:0]   row_bits,
    input  logic [COORD_W-1:0] column,
    input  logic               row_valid,
    input  logic               centre,
    output logic [1:0]         partial,
    output logic               centre_bit
);

    logic [COORD_W-1:0] left_col;
    logic [COORD_W-1:0] right_col;
    logic               left_ok;
    logic               right_ok;
    logic               left_bit;
    logic               mid_bit;
    logic               right_bit;

    function automatic logic pick(input logic [WIDTH-1:0] bits, input logic [COORD_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int k = 0; k < WIDTH; k++)
            if (int'(idx) == k) b = bits[k];
        return b;
    endfunction

    always_comb begin
        left_col  = wrap_dec(column, WIDTH, WRAP);
        right_col = wrap_inc(column, WIDTH);
        left_ok   = WRAP || (column != '0);
        right_ok  = WRAP || (int'(column) != WIDTH - 1);
        left_bit  = row_valid & left_ok & pick(row_bits, left_col);
        mid_bit   = row_valid & pick(row_bits, column);
        right_bit = row_valid & right_ok & pick(row_bits, right_col);
        // The target itself is not its own neighbour.
        partial    = {1'b0, left_bit} + {1'b0, right_bit} + (centre ? 2'b00 : {1'b0, mid_bit});
        centre_bit = mid_bit;
    end

endmodule

// File: rtl/cell_neighbourhood_reader.sv
// Reads rows r-1, r, r+1 from the arena over three cycles and returns the target
// cell plus its live-neighbour count; out-of-range targets report coord_error.
module cell_neighbourhood_reader
    import life_pkg::*;
#(
    parameter int ARENA_WIDTH  = 10,
    parameter int ARENA_HEIGHT = 10,
    parameter bit WRAP         = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   ready,
    input  logic [COORD_W-1:0]     cell_column,
    input  logic [COORD_W-1:0]     cell_row,
    output logic                   done,
    output logic                   cell_value,
    output logic [COUNT_W-1:0]     neighbour_count,
    output logic                   coord_error,
    output logic [COORD_W-1:0]     arena_row_select,
    input  logic [ARENA_WIDTH-1:0] arena_columns
);

    if (ARENA_WIDTH < 3 || ARENA_WIDTH > 256 || ARENA_HEIGHT < 3 || ARENA_HEIGHT > 256) begin : g_param_check
        $error("cell_neighbourhood_reader: arena dimensions must be within 3..256");
    end

    state_t             state;
    state_t             state_next;
    logic [COORD_W-1:0] col_q;
    logic [COORD_W-1:0] row_q;
    logic [COORD_W-1:0] sel_next;
    logic [COUNT_W-1:0] acc;
    logic               cell_q;
    logic               row_valid;
    logic               tap_centre;
    logic [1:0]         partial;
    logic               centre_bit;
    logic               in_range;

    assign in_range = (int'(cell_column) < ARENA_WIDTH) && (int'(cell_row) < ARENA_HEIGHT);

    neighbour_row_tap #(
        .WIDTH (ARENA_WIDTH),
        .WRAP  (WRAP)
    ) u_tap (
        .row_bits   (arena_columns),
        .column     (col_q),
        .row_valid  (row_valid),
        .centre     (tap_centre),
        .partial    (partial),
        .centre_bit (centre_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        sel_next   = '0;
        ready      = 1'b0;
        row_valid  = 1'b0;
        tap_centre = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (in_range) begin
                        state_next = ST_ABOVE;
                        sel_next   = wrap_dec(cell_row, ARENA_HEIGHT, WRAP);
                    end else begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_ABOVE: begin
                row_valid  = WRAP || (row_q != '0);
                state_next = ST_CENTRE;
                sel_next   = row_q;
            end
            ST_CENTRE: begin
                row_valid  = 1'b1;
                tap_centre = 1'b1;
                state_next = ST_BELOW;
                sel_next   = wrap_inc(row_q, ARENA_HEIGHT);
            end
            ST_BELOW: begin
                row_valid  = WRAP || (int'(row_q) != ARENA_HEIGHT - 1);
                state_next = ST_IDLE;
            end
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Results only change when a read completes, so an aborted read never shows partial data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q            <= '0;
            row_q            <= '0;
            acc              <= '0;
            cell_q           <= 1'b0;
            arena_row_select <= '0;
            done             <= 1'b0;
            cell_value       <= 1'b0;
            neighbour_count  <= '0;
            coord_error      <= 1'b0;
        end else begin
            arena_row_select <= sel_next;
            done             <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        col_q <= cell_column;
                        row_q <= cell_row;
                        acc   <= '0;
                    end
                end
                ST_ABOVE:  acc <= acc + {2'b00, partial};
                ST_CENTRE: begin
                    acc    <= acc + {2'b00, partial};
                    cell_q <= centre_bit;
                end
                ST_BELOW: begin
                    neighbour_count <= acc + {2'b00, partial};
                    cell_value      <= cell_q;
                    coord_error     <= 1'b0;
                    done            <= 1'b1;
                end
                ST_ERR: begin
                    neighbour_count <= '0;
                    cell_value      <= 1'b0;
                    coord_error     <= 1'b1;
                    done            <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_neighbourhood_reader.sv
// Directed bench: a toroidal and a dead-border 10x10 reader share one modelled arena.
module tb_cell_neighbourhood_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cell_column = '0;
    logic [7:0] cell_row = '0;

    logic       ready_a, done_a, cell_a, err_a;
    logic [3:0] cnt_a;
    logic [7:0] sel_a;
    logic [9:0] cols_a;
    logic       ready_b, done_b, cell_b, err_b;
    logic [3:0] cnt_b;
    logic [7:0] sel_b;
    logic [9:0] cols_b;

    logic [9:0] arena [0:255];
    assign cols_a = arena[sel_a];
    assign cols_b = arena[sel_b];

    always #5 clk = ~clk;

    cell_neighbourhood_reader #(.ARENA_WIDTH(10), .ARENA_HEIGHT(10), .WRAP(1'b1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .ready(ready_a),
        .cell_column(cell_column), .cell_row(cell_row), .done(done_a),
        .cell_value(cell_a), .neighbour_count(cnt_a), .coord_error(err_a),
        .arena_row_select(sel_a), .arena_columns(cols_a)
    );

    cell_neighbourhood_reader #(.ARENA_WIDTH(10), .ARENA_HEIGHT(10), .WRAP(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .ready(ready_b),
        .cell_column(cell_column), .cell_row(cell_row), .done(done_b),
        .cell_value(cell_b), .neighbour_count(cnt_b), .coord_error(err_b),
        .arena_row_select(sel_b), .arena_columns(cols_b)
    );

    int          errors = 0;
    int          checks = 0;
    logic [23:0] seq_a, seq_b;
    int          dat_a, dat_b, nd_a, nd_b;
    logic        busy_a;
    logic [15:0] mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start at edge T; cycle T+i is observed at the i-th following negedge.
    task automatic do_read(input logic [7:0] c, input logic [7:0] r, input bit poke);
        seq_a = '0; seq_b = '0; dat_a = 0; dat_b = 0; nd_a = 0; nd_b = 0;
        @(negedge clk);
        start = 1'b1; cell_column = c; cell_row = r;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            start = poke && (i == 2);
            if (poke && i == 2) begin cell_column = 8'd4; cell_row = 8'd4; end
            if (i <= 3) begin
                seq_a = {seq_a[15:0], sel_a};
                seq_b = {seq_b[15:0], sel_b};
            end
            if (i == 2) busy_a = ready_a;
            if (done_a) begin nd_a++; dat_a = i; end
            if (done_b) begin nd_b++; dat_b = i; end
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) arena[k] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready_a), 32'd1);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_cell", 32'(cell_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_sel", 32'(sel_a), 32'd0);
        chk("rst_ready_b", 32'(ready_b), 32'd1);

        arena[5] = 10'b0001110000;
        do_read(8'd5, 8'd5, 1'b0);
        chk("blk_cell", 32'(cell_a), 32'd1);
        chk("blk_count", 32'(cnt_a), 32'd2);
        chk("blk_done_at", 32'(dat_a), 32'd4);
        chk("blk_ndone", 32'(nd_a), 32'd1);
        chk("blk_sel", 32'(seq_a), {8'd0, 8'd4, 8'd5, 8'd6});
        chk("blk_busy", 32'(busy_a), 32'd0);
        chk("blk_count_b", 32'(cnt_b), 32'd2);
        chk("blk_done_at_b", 32'(dat_b), 32'd4);

        arena[5] = '0;
        arena[9] = 10'b1000000001;
        arena[0] = 10'b1000000000;
        do_read(8'd0, 8'd0, 1'b0);
        chk("crn_count_w", 32'(cnt_a), 32'd3);
        chk("crn_cell_w", 32'(cell_a), 32'd0);
        chk("crn_sel_w", 32'(seq_a), {8'd0, 8'd9, 8'd0, 8'd1});
        chk("crn_count_d", 32'(cnt_b), 32'd0);
        chk("crn_cell_d", 32'(cell_b), 32'd0);
        chk("crn_sel_d", 32'(seq_b), {8'd0, 8'd0, 8'd0, 8'd1});

        for (int k = 0; k < 10; k++) arena[k] = 10'h3FF;
        do_read(8'd4, 8'd4, 1'b0);
        chk("all_mid_w", 32'(cnt_a), 32'd8);
        chk("all_mid_d", 32'(cnt_b), 32'd8);
        chk("all_mid_cell", 32'(cell_a), 32'd1);
        do_read(8'd0, 8'd0, 1'b0);
        chk("all_crn_w", 32'(cnt_a), 32'd8);
        chk("all_crn_d", 32'(cnt_b), 32'd3);
        chk("all_crn_err", 32'(err_a), 32'd0);

        do_read(8'd10, 8'd2, 1'b0);
        chk("err_flag", 32'(err_a), 32'd1);
        chk("err_count", 32'(cnt_a), 32'd0);
        chk("err_cell", 32'(cell_a), 32'd0);
        chk("err_done_at", 32'(dat_a), 32'd2);
        chk("err_sel", 32'(seq_a), 32'd0);
        chk("err_flag_b", 32'(err_b), 32'd1);

        do_read(8'd0, 8'd0, 1'b1);
        chk("ign_count_d", 32'(cnt_b), 32'd3);
        chk("ign_err_d", 32'(err_b), 32'd0);
        chk("ign_ndone_d", 32'(nd_b), 32'd1);
        chk("ign_done_at", 32'(dat_a), 32'd4);

        mask = '0;
        @(negedge clk);
        start = 1'b1; cell_column = 8'd4; cell_row = 8'd4;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 9) start = 1'b0;
            if (done_a) mask[i] = 1'b1;
        end
        chk("b2b_done_mask", 32'(mask), 32'h1110);
        chk("b2b_count", 32'(cnt_a), 32'd8);

        @(negedge clk);
        start = 1'b1; cell_column = 8'd0; cell_row = 8'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_count", 32'(cnt_a), 32'd0);
        chk("abort_cell", 32'(cell_a), 32'd0);
        chk("abort_done", 32'(done_a), 32'd0);
        chk("abort_sel", 32'(sel_a), 32'd0);
        nd_a = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done_a) nd_a++;
        end
        chk("abort_no_done", 32'(nd_a), 32'd0);
        chk("abort_count_after", 32'(cnt_a), 32'd0);
        chk("abort_ready", 32'(ready_a), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
